// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the cheese controller, the
// game-over check and the draw stage.
package game_pkg;

    typedef enum logic [1:0] {
        SPAWN,
        VISIBLE,
        HIDDEN,
        DONE
    } cheese_state_t;

    localparam int CHEESE_W      = 16;
    localparam int CHEESE_H      = 16;
    localparam int CHEESE_TARGET = 20;

    // Strict axis-aligned box intersection; boxes that only share an edge
    // do not intersect. 13-bit operands keep position+size from wrapping.
    function automatic logic rect_overlap(
        input logic [12:0] ax, input logic [12:0] ay,
        input logic [12:0] aw, input logic [12:0] ah,
        input logic [12:0] bx, input logic [12:0] by,
        input logic [12:0] bw, input logic [12:0] bh
    );
        return (ax < bx + bw) && (bx < ax + aw) &&
               (ay < by + bh) && (by < ay + ah);
    endfunction

endpackage

// File: rtl/pos_if.sv
// pos_if: a 12-bit unsigned screen position (top-left corner).
interface pos_if;
    logic [11:0] x;
    logic [11:0] y;

    modport in  (input  x, input  y);
    modport out (output x, output y);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR with a loadable seed.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    // Shift right; when the bit falling off is 1, fold the tap mask back in.
    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED;
        else if (en)
            state <= {1'b0, state[15:1]} ^ (state[0] ? MASK : 16'h0000);
    end

endmodule

// File: rtl/cheese_ctrl.sv
// cheese_ctrl: owns the single cheese -- rejection-sampled spawn inside the
// playfield away from Jerry, collection on overlap, counting up to TARGET,
// then respawn. Optional macro CHEESE_RESPAWN_DELAY_EN inserts a delay of
// RESPAWN_FRAMES frame ticks before each respawn; without it the cheese is
// hidden for a single cycle.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   SPAWN   | drawing LFSR candidates until one fits and misses Jerry
//   VISIBLE | cheese on screen, waiting for Jerry to touch it
//   HIDDEN  | just collected, waiting to respawn
//   DONE    | TARGET collected, frozen until reset
module cheese_ctrl #(
    parameter int          CHEESE_W       = game_pkg::CHEESE_W,
    parameter int          CHEESE_H       = game_pkg::CHEESE_H,
    parameter int          JERRY_W        = 32,
    parameter int          JERRY_H        = 32,
    parameter int          X_MIN          = 0,
    parameter int          X_MAX          = 1023,
    parameter int          Y_MIN          = 0,
    parameter int          Y_MAX          = 767,
    parameter int          TARGET         = game_pkg::CHEESE_TARGET,
    parameter int          RESPAWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        game_run,
    pos_if.in           jerrypos,
    output logic [7:0]  cheese_ctr,
    output logic [11:0] cheese_x,
    output logic [11:0] cheese_y,
    output logic        cheese_visible,
    output logic        collect_pulse
);
    import game_pkg::*;

    if (TARGET < 1 || TARGET > 255 || RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255) begin : g_bad_params
        $error("cheese_ctrl: TARGET and RESPAWN_FRAMES must lie in 1..255");
    end

    localparam logic [12:0] X_LO = 13'(X_MIN);
    localparam logic [12:0] X_HI = 13'(X_MAX - CHEESE_W);
    localparam logic [12:0] Y_LO = 13'(Y_MIN);
    localparam logic [12:0] Y_HI = 13'(Y_MAX - CHEESE_H);
    localparam logic [12:0] CW   = 13'(CHEESE_W);
    localparam logic [12:0] CH   = 13'(CHEESE_H);
    localparam logic [12:0] JW   = 13'(JERRY_W);
    localparam logic [12:0] JH   = 13'(JERRY_H);
    localparam logic [7:0]  TGT  = 8'(TARGET);

    cheese_state_t state, state_nxt;
    logic [15:0]   lfsr;
    logic [12:0]   cand_x, cand_y, jx, jy, cur_x, cur_y;
    logic [13:0]   dx_lo, dy_lo;
    logic          cand_ok, cand_hit, cur_hit;
    logic [11:0]   x_nxt, y_nxt;
    logic [7:0]    ctr_nxt, ctr_inc;
    logic          pulse_nxt;

    // Free-running: the random stream must not stall while the game is paused.
    lfsr16 #(
        .SEED (LFSR_SEED),
        .MASK (16'hB400)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    assign cand_x  = {2'b00, lfsr[10:0]};
    assign cand_y  = {3'b000, lfsr[15:6]};
    assign jx      = {1'b0, jerrypos.x};
    assign jy      = {1'b0, jerrypos.y};
    assign cur_x   = {1'b0, cheese_x};
    assign cur_y   = {1'b0, cheese_y};
    assign ctr_inc = cheese_ctr + 8'd1;

    // Lower bounds via a borrow bit so a zero bound does not become a
    // constant-true comparison.
    assign dx_lo    = {1'b0, cand_x} - {1'b0, X_LO};
    assign dy_lo    = {1'b0, cand_y} - {1'b0, Y_LO};
    assign cand_hit = rect_overlap(jx, jy, JW, JH, cand_x, cand_y, CW, CH);
    assign cur_hit  = rect_overlap(jx, jy, JW, JH, cur_x, cur_y, CW, CH);
    assign cand_ok  = !dx_lo[13] && (cand_x <= X_HI) &&
                      !dy_lo[13] && (cand_y <= Y_HI) && !cand_hit;

`ifdef CHEESE_RESPAWN_DELAY_EN
    logic [7:0] dly, dly_nxt;
`endif

    // Next-state and next-output logic; everything holds while game_run is low.
    always_comb begin
        state_nxt = state;
        x_nxt     = cheese_x;
        y_nxt     = cheese_y;
        ctr_nxt   = cheese_ctr;
        pulse_nxt = 1'b0;
`ifdef CHEESE_RESPAWN_DELAY_EN
        dly_nxt   = dly;
`endif
        if (game_run) begin
            case (state)
                SPAWN: begin
                    if (cand_ok) begin
                        x_nxt     = cand_x[11:0];
                        y_nxt     = cand_y[11:0];
                        state_nxt = VISIBLE;
                    end
                end
                VISIBLE: begin
                    if (cur_hit) begin
                        ctr_nxt   = ctr_inc;
                        pulse_nxt = 1'b1;
                        state_nxt = (ctr_inc == TGT) ? DONE : HIDDEN;
`ifdef CHEESE_RESPAWN_DELAY_EN
                        dly_nxt   = 8'(RESPAWN_FRAMES);
`endif
                    end
                end
                HIDDEN: begin
`ifdef CHEESE_RESPAWN_DELAY_EN
                    if (dly == 8'd0)
                        state_nxt = SPAWN;
                    else if (frame_tick)
                        dly_nxt = dly - 8'd1;
`else
                    state_nxt = SPAWN;
`endif
                end
                default: ;
            endcase
        end
    end

    // State and registered outputs; reset wins over any same-cycle collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SPAWN;
            cheese_ctr     <= 8'd0;
            cheese_x       <= 12'(X_MIN);
            cheese_y       <= 12'(Y_MIN);
            cheese_visible <= 1'b0;
            collect_pulse  <= 1'b0;
        end else begin
            state          <= state_nxt;
            cheese_ctr     <= ctr_nxt;
            cheese_x       <= x_nxt;
            cheese_y       <= y_nxt;
            cheese_visible <= (state_nxt == VISIBLE);
            collect_pulse  <= pulse_nxt;
        end
    end

`ifdef CHEESE_RESPAWN_DELAY_EN
    // Respawn delay counter, loaded when a collection sends us to HIDDEN.
    always_ff @(posedge clk) begin
        if (rst)
            dly <= 8'd0;
        else
            dly <= dly_nxt;
    end
`endif

endmodule

// File: tb/tb_cheese_ctrl.sv
// tb_cheese_ctrl: directed-plus-random bench for cheese_ctrl with a
// behavioural reference model of the cheese game rules.
module tb_cheese_ctrl;

    localparam int RESP = 3;
    localparam int TGT  = 20;
    localparam int SEED = 'hACE1;
    localparam int PH_SPAWN = 0, PH_SHOW = 1, PH_WAIT = 2, PH_DONE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        game_run = 1'b0;
    logic [7:0]  cheese_ctr;
    logic [11:0] cheese_x, cheese_y;
    logic        cheese_visible, collect_pulse;

    pos_if jp ();

    cheese_ctrl #(
        .RESPAWN_FRAMES (RESP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .game_run       (game_run),
        .jerrypos       (jp),
        .cheese_ctr     (cheese_ctr),
        .cheese_x       (cheese_x),
        .cheese_y       (cheese_y),
        .cheese_visible (cheese_visible),
        .collect_pulse  (collect_pulse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int m_lfsr, m_ph, m_ctr, m_x, m_y, m_dly;
    bit m_pulse, m_vis;

    function automatic bit hits(input int ax, input int ay, input int aw, input int ah,
                                input int bx, input int by, input int bw, input int bh);
        return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
    endfunction

    task automatic model_update(input bit r, input bit run, input bit tick, input int jx, input int jy);
        int cx, cy;
        if (r) begin
            m_lfsr = SEED; m_ph = PH_SPAWN; m_ctr = 0; m_x = 0; m_y = 0;
            m_pulse = 0; m_dly = 0;
        end else begin
            m_pulse = 0;
            if (run) begin
                case (m_ph)
                    PH_SPAWN: begin
                        cx = m_lfsr % 2048;
                        cy = m_lfsr / 64;
                        if (cx <= 1023 - 16 && cy <= 767 - 16 && !hits(jx, jy, 32, 32, cx, cy, 16, 16)) begin
                            m_x = cx; m_y = cy; m_ph = PH_SHOW;
                        end
                    end
                    PH_SHOW: begin
                        if (hits(jx, jy, 32, 32, m_x, m_y, 16, 16)) begin
                            m_ctr++;
                            m_pulse = 1;
                            m_ph = (m_ctr == TGT) ? PH_DONE : PH_WAIT;
                            m_dly = RESP;
                        end
                    end
                    PH_WAIT: begin
`ifdef CHEESE_RESPAWN_DELAY_EN
                        if (m_dly == 0) m_ph = PH_SPAWN;
                        else if (tick) m_dly--;
`else
                        m_ph = PH_SPAWN;
`endif
                    end
                    default: ;
                endcase
            end
            m_lfsr = (m_lfsr / 2) ^ ((m_lfsr % 2) ? 'hB400 : 0);
        end
        m_vis = (m_ph == PH_SHOW);
    endtask

    task automatic check_outputs();
        n_vec++;
        assert (cheese_ctr === 8'(m_ctr)) else begin
            n_bad++; $error("FAIL ctr: observed %0d expected %0d", cheese_ctr, m_ctr);
        end
        assert (cheese_x === 12'(m_x)) else begin
            n_bad++; $error("FAIL cheese_x: observed %0d expected %0d", cheese_x, m_x);
        end
        assert (cheese_y === 12'(m_y)) else begin
            n_bad++; $error("FAIL cheese_y: observed %0d expected %0d", cheese_y, m_y);
        end
        assert (cheese_visible === m_vis) else begin
            n_bad++; $error("FAIL visible: observed %b expected %b", cheese_visible, m_vis);
        end
        assert (collect_pulse === m_pulse) else begin
            n_bad++; $error("FAIL pulse: observed %b expected %b", collect_pulse, m_pulse);
        end
    endtask

    task automatic cycle(input bit r, input bit run, input bit tick, input int jx, input int jy);
        rst = r; game_run = run; frame_tick = tick;
        jp.x = 12'(jx); jp.y = 12'(jy);
        @(posedge clk);
        model_update(r, run, tick, jx, jy);
        #1;
        check_outputs();
    endtask

    task automatic wait_visible(input int budget, input string tag);
        for (int i = 0; i < budget && !m_vis; i++)
            cycle(0, 1, 1'($urandom % 2), 900, 700);
        assert (cheese_visible === 1'b1) else begin
            n_bad++; $error("FAIL %s: observed visible %b expected 1", tag, cheese_visible);
        end
    endtask

    initial begin
        int ox, oy, jx, jy, ticks, npulse;
        bit run, tick;

        // reset state
        repeat (3) cycle(1, 1, 0, 900, 700);
        assert (cheese_ctr === 8'd0 && cheese_visible === 1'b0 && collect_pulse === 1'b0) else begin
            n_bad++; $error("FAIL reset: observed ctr %0d vis %b pulse %b expected 0 0 0",
                            cheese_ctr, cheese_visible, collect_pulse);
        end

        // first spawn: inside bounds, clear of Jerry
        wait_visible(200, "first_spawn");
        assert (cheese_x <= 12'd1007 && cheese_y <= 12'd751) else begin
            n_bad++; $error("FAIL spawn_bounds: observed (%0d,%0d) expected <= (1007,751)", cheese_x, cheese_y);
        end
        assert (!hits(900, 700, 32, 32, cheese_x, cheese_y, 16, 16)) else begin
            n_bad++; $error("FAIL spawn_clear: observed cheese (%0d,%0d) overlapping Jerry expected clear", cheese_x, cheese_y);
        end

        // collection: Jerry dropped onto the cheese
        cycle(0, 1, 0, m_x, m_y);
        assert (cheese_ctr === 8'd1 && collect_pulse === 1'b1 && cheese_visible === 1'b0) else begin
            n_bad++; $error("FAIL collect: observed ctr %0d pulse %b vis %b expected 1 1 0",
                            cheese_ctr, collect_pulse, cheese_visible);
        end
        cycle(0, 1, 0, 900, 700);
        assert (collect_pulse === 1'b0) else begin
            n_bad++; $error("FAIL pulse_width: observed %b expected 0", collect_pulse);
        end

`ifdef CHEESE_RESPAWN_DELAY_EN
        // pause during HIDDEN: ticks must not advance the delay
        repeat (6) cycle(0, 0, 1, 900, 700);
        assert (cheese_visible === 1'b0) else begin
            n_bad++; $error("FAIL hidden_hold: observed visible %b expected 0", cheese_visible);
        end
        ticks = 0;
        for (int i = 0; i < 200 && cheese_visible !== 1'b1; i++) begin
            tick = (i % 4) == 3;
            if (tick) ticks++;
            cycle(0, 1, tick, 900, 700);
        end
        assert (cheese_visible === 1'b1 && ticks >= RESP) else begin
            n_bad++; $error("FAIL respawn_delay: observed %0d ticks before visible expected >= %0d", ticks, RESP);
        end
`else
        wait_visible(200, "respawn");
`endif

        // edge-touching from right, below and left: no collection
        repeat (3) cycle(0, 1, 0, m_x + 16, m_y);
        repeat (3) cycle(0, 1, 0, m_x, m_y + 16);
        if (m_x >= 32) repeat (3) cycle(0, 1, 0, m_x - 32, m_y);
        assert (cheese_ctr === 8'd1 && cheese_visible === 1'b1) else begin
            n_bad++; $error("FAIL edge_touch: observed ctr %0d vis %b expected 1 1", cheese_ctr, cheese_visible);
        end

        // paused while overlapping: no collection
        cycle(0, 0, 0, m_x, m_y);
        assert (collect_pulse === 1'b0 && cheese_ctr === 8'd1) else begin
            n_bad++; $error("FAIL paused_overlap: observed pulse %b ctr %0d expected 0 1", collect_pulse, cheese_ctr);
        end

        // random play
        for (int i = 0; i < 3000 && m_ctr < TGT; i++) begin
            run  = ($urandom % 8) != 0;
            tick = ($urandom % 3) == 0;
            if (m_vis && ($urandom % 4) == 0) begin
                jx = m_x + int'($urandom_range(0, 40)) - 30;
                jy = m_y + int'($urandom_range(0, 40)) - 30;
                if (jx < 0) jx = 0;
                if (jy < 0) jy = 0;
            end else begin
                jx = int'($urandom_range(0, 1023));
                jy = int'($urandom_range(0, 767));
            end
            cycle(0, run, tick, jx, jy);
        end

        // drive to the target
        for (int i = 0; i < 5000 && m_ctr < TGT; i++) begin
            if (m_vis) cycle(0, 1, 1'($urandom % 2), m_x, m_y);
            else       cycle(0, 1, 1'($urandom % 2), 900, 700);
        end
        assert (cheese_ctr === 8'(TGT) && cheese_visible === 1'b0) else begin
            n_bad++; $error("FAIL target: observed ctr %0d vis %b expected %0d 0", cheese_ctr, cheese_visible, TGT);
        end

        // DONE: Jerry parked on the last cheese spot, nothing more happens
        ox = m_x; oy = m_y; npulse = 0;
        repeat (50) begin
            cycle(0, 1, 1'($urandom % 2), ox, oy);
            if (collect_pulse === 1'b1) npulse++;
        end
        assert (npulse === 0 && cheese_ctr === 8'(TGT)) else begin
            n_bad++; $error("FAIL done_hold: observed %0d pulses ctr %0d expected 0 %0d", npulse, cheese_ctr, TGT);
        end

        // reset in the same cycle as an overlap
        cycle(1, 1, 0, 900, 700);
        wait_visible(200, "spawn_after_rst");
        cycle(1, 1, 0, m_x, m_y);
        assert (cheese_ctr === 8'd0 && collect_pulse === 1'b0 && cheese_visible === 1'b0) else begin
            n_bad++; $error("FAIL rst_vs_collect: observed ctr %0d pulse %b vis %b expected 0 0 0",
                            cheese_ctr, collect_pulse, cheese_visible);
        end
        wait_visible(200, "spawn_after_rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
